// File: rtl/calc_entry_ctrl_pkg.sv
// Package for the calculator keypad-to-ALU controller.
// Holds key codes, the controller state encoding and key classification helpers.
package calc_pkg;

    localparam logic [3:0] KEY_EQ  = 4'd10;
    localparam logic [3:0] KEY_AC  = 4'd11;
    localparam logic [3:0] KEY_ADD = 4'd12;
    localparam logic [3:0] KEY_SUB = 4'd13;
    localparam logic [3:0] KEY_MUL = 4'd14;
    localparam logic [3:0] KEY_DIV = 4'd15;

    typedef enum logic [2:0] {
        S_NUM1 = 3'd0,
        S_NUM2 = 3'd1,
        S_CALC = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k < 4'd10;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return k >= KEY_ADD;
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Bus between the calculator controller and its surroundings (keypad, ALU, display).
//   master : the controller (drives ALU request/operands, display, status)
//   slave  : the environment (drives keys, ALU acknowledge/result)
interface calc_entry_ctrl_if #(
    parameter int unsigned NDIGITS = 4
);
    localparam int unsigned W = 4 * NDIGITS;

    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic         alu_req;
    logic         alu_ack;
    logic [W-1:0] alu_res;
    logic         alu_err;
    logic [W-1:0] display;
    logic         disp_err;
    logic         busy;
    logic [2:0]   state;

    modport master (
        input  key_valid, key_code, alu_ack, alu_res, alu_err,
        output alu_a, alu_b, alu_op, alu_req, display, disp_err, busy, state
    );

    modport slave (
        output key_valid, key_code, alu_ack, alu_res, alu_err,
        input  alu_a, alu_b, alu_op, alu_req, display, disp_err, busy, state
    );
endinterface

// File: rtl/calc_entry_ctrl_bcd_entry_reg.sv
// BCD operand entry register.
// Shifts a digit in at the low end, tracks how many significant digits are held,
// suppresses leading zeros and stops accepting digits once NDIGITS are held.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_clear      clear value and count (highest priority)
//   i_load       parallel load of i_load_val (count = significant digits)
//   i_shift      shift in i_digit
//   o_value      current BCD value
//   o_count      number of significant digits held
module bcd_entry_reg #(
    parameter int unsigned NDIGITS = 4,
    localparam int unsigned W  = 4 * NDIGITS,
    localparam int unsigned CW = $clog2(NDIGITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_val,
    input  logic          i_shift,
    input  logic [3:0]    i_digit,
    output logic [W-1:0]  o_value,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_value;
    logic [CW-1:0] r_count;

    // Index of the most significant non-zero digit, plus one.
    function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) n = CW'(i + 1);
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
            r_count <= sig_digits(i_load_val);
        end else if (i_shift && (r_count < CW'(NDIGITS))) begin
            // A zero typed into an empty entry is a leading zero: nothing changes.
            if (!((r_value == '0) && (i_digit == 4'd0))) begin
                r_value <= {r_value[W-5:0], i_digit};
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;
endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU controller for the FPGA calculator.
// Builds two BCD operands from key strobes, issues operations to a variable-latency
// ALU with req/ack, supports chained operations, repeat-equals and an error display.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          keypad inputs, ALU handshake/operands, display and status outputs
module calc_entry_ctrl #(
    parameter int unsigned NDIGITS          = 4,
    parameter int unsigned ALU_TIMEOUT      = 64,
    parameter logic [4*NDIGITS-1:0] ERR_PATTERN = {NDIGITS{4'hE}}
) (
    input  logic              clk,
    input  logic              reset,
    calc_entry_ctrl_if.master bus
);
    import calc_pkg::*;

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned CW = $clog2(NDIGITS + 1);
    localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);

    state_e        r_state, w_state_d;
    logic [3:0]    r_op, w_op_d;
    logic [3:0]    r_pend, w_pend_d;
    logic          r_chain, w_chain_d;
    logic [TW-1:0] r_tmo;
    logic [W-1:0]  r_display, w_display_d;

    logic          w_n1_clear, w_n1_load, w_n1_shift;
    logic [W-1:0]  w_n1_load_val, w_num1;
    logic [CW-1:0] w_n1_count;
    logic          w_n2_clear, w_n2_load, w_n2_shift;
    logic [W-1:0]  w_num2;
    logic [CW-1:0] w_n2_count;

    logic          w_kv, w_digit, w_op, w_timeout;
    logic [3:0]    w_key;

    assign w_kv      = bus.key_valid;
    assign w_key     = bus.key_code;
    assign w_digit   = is_digit(w_key);
    assign w_op      = is_op(w_key);
    assign w_timeout = (r_tmo == TW'(ALU_TIMEOUT - 1));

    bcd_entry_reg #(.NDIGITS(NDIGITS)) u_num1 (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_n1_clear),
        .i_load     (w_n1_load),
        .i_load_val (w_n1_load_val),
        .i_shift    (w_n1_shift),
        .i_digit    (w_key),
        .o_value    (w_num1),
        .o_count    (w_n1_count)
    );

    bcd_entry_reg #(.NDIGITS(NDIGITS)) u_num2 (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_n2_clear),
        .i_load     (w_n2_load),
        .i_load_val (w_num1),
        .i_shift    (w_n2_shift),
        .i_digit    (w_key),
        .o_value    (w_num2),
        .o_count    (w_n2_count)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_NUM1;
        else       r_state <= w_state_d;
    end

    // Next state and entry/op register controls.
    always_comb begin
        w_state_d     = r_state;
        w_op_d        = r_op;
        w_pend_d      = r_pend;
        w_chain_d     = r_chain;
        w_n1_clear    = 1'b0;
        w_n1_load     = 1'b0;
        w_n1_shift    = 1'b0;
        w_n1_load_val = bus.alu_res;
        w_n2_clear    = 1'b0;
        w_n2_load     = 1'b0;
        w_n2_shift    = 1'b0;
        case (r_state)
            S_NUM1: if (w_kv) begin
                if (w_digit) begin
                    w_n1_shift = 1'b1;
                end else if (w_op) begin
                    w_op_d     = w_key;
                    w_n2_clear = 1'b1;
                    w_state_d  = S_NUM2;
                end else if (w_key == KEY_AC) begin
                    w_n1_clear = 1'b1;
                end
            end
            S_NUM2: if (w_kv) begin
                if (w_digit) begin
                    w_n2_shift = 1'b1;
                end else if (w_op) begin
                    if (w_n2_count == '0) begin
                        w_op_d = w_key;
                    end else begin
                        w_chain_d = 1'b1;
                        w_pend_d  = w_key;
                        w_state_d = S_CALC;
                    end
                end else if (w_key == KEY_EQ) begin
                    // "a op =" with no second operand uses a as b.
                    w_n2_load = (w_n2_count == '0);
                    w_chain_d = 1'b0;
                    w_state_d = S_CALC;
                end else begin
                    w_n2_clear = 1'b1;
                    if (w_n2_count == '0) begin
                        w_n1_clear = 1'b1;
                        w_op_d     = 4'd0;
                        w_chain_d  = 1'b0;
                        w_state_d  = S_NUM1;
                    end
                end
            end
            S_CALC: begin
                // Keys are dropped here, even when they coincide with alu_ack.
                if (bus.alu_ack) begin
                    if (bus.alu_err) begin
                        w_chain_d = 1'b0;
                        w_state_d = S_ERR;
                    end else begin
                        w_n1_load = 1'b1;
                        if (r_chain) begin
                            w_op_d     = r_pend;
                            w_n2_clear = 1'b1;
                            w_chain_d  = 1'b0;
                            w_state_d  = S_NUM2;
                        end else begin
                            w_state_d  = S_RES;
                        end
                    end
                end else if (w_timeout) begin
                    w_chain_d = 1'b0;
                    w_state_d = S_ERR;
                end
            end
            S_RES: if (w_kv) begin
                if (w_digit) begin
                    w_n1_load     = 1'b1;
                    w_n1_load_val = W'(w_key);
                    w_state_d     = S_NUM1;
                end else if (w_op) begin
                    w_op_d     = w_key;
                    w_n2_clear = 1'b1;
                    w_state_d  = S_NUM2;
                end else if (w_key == KEY_EQ) begin
                    w_state_d = S_CALC;
                end else begin
                    w_n1_clear = 1'b1;
                    w_n2_clear = 1'b1;
                    w_op_d     = 4'd0;
                    w_state_d  = S_NUM1;
                end
            end
            S_ERR: if (w_kv && (w_key == KEY_AC)) begin
                w_n1_clear = 1'b1;
                w_n2_clear = 1'b1;
                w_op_d     = 4'd0;
                w_chain_d  = 1'b0;
                w_state_d  = S_NUM1;
            end
            default: w_state_d = S_NUM1;
        endcase
    end

    // Display source for the next edge; it lags the key action by one edge.
    always_comb begin
        w_display_d = r_display;
        case (r_state)
            S_NUM1:  w_display_d = (w_n1_count == '0) ? '0 : w_num1;
            S_NUM2:  w_display_d = (w_n2_count == '0) ? w_num1 : w_num2;
            S_CALC:  w_display_d = r_display;
            S_RES:   w_display_d = w_num1;
            S_ERR:   w_display_d = ERR_PATTERN;
            default: w_display_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= 4'd0;
            r_pend    <= 4'd0;
            r_chain   <= 1'b0;
            r_tmo     <= '0;
            r_display <= '0;
        end else begin
            r_op      <= w_op_d;
            r_pend    <= w_pend_d;
            r_chain   <= w_chain_d;
            r_tmo     <= (r_state == S_CALC) ? r_tmo + TW'(1) : '0;
            r_display <= w_display_d;
        end
    end

    // Outputs decoded straight from state so reset drops alu_req immediately.
    always_comb begin
        bus.alu_req  = (r_state == S_CALC);
        bus.busy     = (r_state == S_CALC);
        bus.disp_err = (r_state == S_ERR);
        bus.alu_a    = w_num1;
        bus.alu_b    = w_num2;
        bus.alu_op   = r_op;
        bus.display  = r_display;
        bus.state    = r_state;
    end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;
    import calc_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    calc_entry_ctrl_if #(.NDIGITS(4)) bus ();

    calc_entry_ctrl #(
        .NDIGITS     (4),
        .ALU_TIMEOUT (64),
        .ERR_PATTERN (16'hEEEE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic reply(input int dly, input logic [15:0] res, input logic err);
        repeat (dly) @(negedge clk);
        bus.alu_ack = 1'b1;
        bus.alu_res = res;
        bus.alu_err = err;
        @(negedge clk);
        bus.alu_ack = 1'b0;
        bus.alu_err = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.alu_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, bus.alu_req}, 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.alu_ack   = 1'b0;
        bus.alu_res   = 16'd0;
        bus.alu_err   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state",   32'(bus.state), 32'd0);
        check("rst_display", 32'(bus.display), 32'd0);
        check("rst_req",     32'(bus.alu_req), 32'd0);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_derr",    32'(bus.disp_err), 32'd0);
        check("rst_op",      32'(bus.alu_op), 32'd0);

        // 123 + 45 =
        press(4'd1); press(4'd2); press(4'd3); press(KEY_ADD); press(4'd4); press(4'd5);
        press(KEY_EQ);
        wait_req();
        check("add_a",    32'(bus.alu_a), 32'h0123);
        check("add_b",    32'(bus.alu_b), 32'h0045);
        check("add_op",   32'(bus.alu_op), 32'd12);
        check("add_busy", 32'(bus.busy), 32'd1);
        reply(3, 16'h0168, 1'b0);
        check("add_req_low", 32'(bus.alu_req), 32'd0);
        check("add_state",   32'(bus.state), 32'd3);
        @(negedge clk);
        check("add_disp",    32'(bus.display), 32'h0168);
        // digit after a result starts a new number
        press(4'd4);
        check("res_dig_state", 32'(bus.state), 32'd0);
        check("res_dig_a",     32'(bus.alu_a), 32'h0004);
        press(KEY_AC);

        // digit limit and leading zeros
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("limit_a", 32'(bus.alu_a), 32'h1234);
        @(negedge clk);
        check("limit_disp", 32'(bus.display), 32'h1234);
        press(KEY_AC);
        press(4'd0); press(4'd0); press(4'd7);
        check("lz_a", 32'(bus.alu_a), 32'h0007);
        press(4'd8); press(4'd9); press(4'd1); press(4'd2);
        check("lz_count", 32'(bus.alu_a), 32'h7891);
        // op with empty num2 replaces the op; AC with empty num2 clears everything
        press(KEY_ADD); press(KEY_MUL);
        check("oprep_state", 32'(bus.state), 32'd1);
        check("oprep_op",    32'(bus.alu_op), 32'd14);
        press(KEY_AC);
        check("ac_all_state", 32'(bus.state), 32'd0);
        check("ac_all_a",     32'(bus.alu_a), 32'd0);
        check("ac_all_op",    32'(bus.alu_op), 32'd0);

        // chained: 9 + 1 - 3 =
        press(4'd9); press(KEY_ADD); press(4'd1); press(KEY_SUB);
        wait_req();
        check("ch1_a",  32'(bus.alu_a), 32'h0009);
        check("ch1_b",  32'(bus.alu_b), 32'h0001);
        check("ch1_op", 32'(bus.alu_op), 32'd12);
        reply(1, 16'h0010, 1'b0);
        check("ch_state", 32'(bus.state), 32'd1);
        check("ch_op",    32'(bus.alu_op), 32'd13);
        @(negedge clk);
        check("ch_disp",  32'(bus.display), 32'h0010);
        press(4'd3); press(KEY_EQ);
        wait_req();
        check("ch2_a",  32'(bus.alu_a), 32'h0010);
        check("ch2_b",  32'(bus.alu_b), 32'h0003);
        check("ch2_op", 32'(bus.alu_op), 32'd13);
        reply(1, 16'h0007, 1'b0);
        check("ch2_state", 32'(bus.state), 32'd3);

        // 8 / 0 = with ALU error; empty num2 takes num1
        press(KEY_AC);
        press(4'd8); press(KEY_DIV); press(4'd0); press(KEY_EQ);
        wait_req();
        check("div_b", 32'(bus.alu_b), 32'h0008);
        reply(2, 16'h0000, 1'b1);
        check("err_state", 32'(bus.state), 32'd4);
        check("err_flag",  32'(bus.disp_err), 32'd1);
        @(negedge clk);
        check("err_disp",  32'(bus.display), 32'hEEEE);
        press(4'd5);
        check("err_dig_state", 32'(bus.state), 32'd4);
        @(negedge clk);
        check("err_dig_disp",  32'(bus.display), 32'hEEEE);
        press(KEY_AC);
        check("err_ac_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        check("err_ac_disp",  32'(bus.display), 32'h0000);
        check("err_ac_flag",  32'(bus.disp_err), 32'd0);

        // ALU never answers
        press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_EQ);
        check("tmo_calc0", 32'(bus.state), 32'd2);
        repeat (60) @(negedge clk);
        check("tmo_calc60", 32'(bus.state), 32'd2);
        repeat (10) @(negedge clk);
        check("tmo_state", 32'(bus.state), 32'd4);
        check("tmo_req",   32'(bus.alu_req), 32'd0);
        press(KEY_AC);

        // 2 + 3 =, dropped keys, repeat-equals
        press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_EQ);
        press(4'd7);
        check("drop_state", 32'(bus.state), 32'd2);
        check("drop_a",     32'(bus.alu_a), 32'h0002);
        check("drop_b",     32'(bus.alu_b), 32'h0003);
        @(negedge clk);
        bus.alu_ack   = 1'b1;
        bus.alu_res   = 16'h0005;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd9;
        @(negedge clk);
        bus.alu_ack   = 1'b0;
        bus.key_valid = 1'b0;
        check("ackkey_state", 32'(bus.state), 32'd3);
        check("ackkey_a",     32'(bus.alu_a), 32'h0005);
        press(KEY_EQ);
        wait_req();
        check("rep1_a",  32'(bus.alu_a), 32'h0005);
        check("rep1_b",  32'(bus.alu_b), 32'h0003);
        check("rep1_op", 32'(bus.alu_op), 32'd12);
        reply(2, 16'h0008, 1'b0);
        press(KEY_EQ);
        wait_req();
        check("rep2_a", 32'(bus.alu_a), 32'h0008);
        check("rep2_b", 32'(bus.alu_b), 32'h0003);

        // reset in the middle of a calculation
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstc_req",   32'(bus.alu_req), 32'd0);
        check("rstc_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        reply(1, 16'h0011, 1'b0);
        check("late_ack_state", 32'(bus.state), 32'd0);
        check("late_ack_a",     32'(bus.alu_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
